// File: rtl/lgdst_adspi_arb_if.sv
// Request/response handshakes for both requesters plus the ADRF 3-wire SPI pins.
interface lgdst_adspi_arb_if;
   logic       req0_valid;
   logic       req0_ready;
   logic       req0_rw;
   logic [6:0] req0_addr;
   logic [7:0] req0_wdata;
   logic       resp0_valid;
   logic [7:0] resp0_rdata;
   logic       req1_valid;
   logic       req1_ready;
   logic       req1_rw;
   logic [6:0] req1_addr;
   logic [7:0] req1_wdata;
   logic       resp1_valid;
   logic [7:0] resp1_rdata;
   logic       ad_spi_cs;
   logic       ad_spi_sclk;
   logic       ad_spi_sdio_o;
   logic       ad_spi_sdio_oe;
   logic       ad_spi_sdio_i;
   logic       busy;

   modport slave (
      input  req0_valid, req0_rw, req0_addr, req0_wdata,
      input  req1_valid, req1_rw, req1_addr, req1_wdata,
      input  ad_spi_sdio_i,
      output req0_ready, resp0_valid, resp0_rdata,
      output req1_ready, resp1_valid, resp1_rdata,
      output ad_spi_cs, ad_spi_sclk, ad_spi_sdio_o, ad_spi_sdio_oe, busy
   );

   modport master (
      output req0_valid, req0_rw, req0_addr, req0_wdata,
      output req1_valid, req1_rw, req1_addr, req1_wdata,
      output ad_spi_sdio_i,
      input  req0_ready, resp0_valid, resp0_rdata,
      input  req1_ready, resp1_valid, resp1_rdata,
      input  ad_spi_cs, ad_spi_sclk, ad_spi_sdio_o, ad_spi_sdio_oe, busy
   );
endinterface

// File: rtl/lgdst_adspi_arb.sv
// Round-robin arbiter for two requesters sharing the ADRF 3-wire SPI bus;
// serialises one 16-bit R/W+addr+data frame at a time and returns read data to its issuer.
module lgdst_adspi_arb #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int IDLE_GAP = 4
) (
   input logic              clk,
   input logic              reset,
   lgdst_adspi_arb_if.slave bus
);
   localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int WMAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > IDLE_GAP) ? CS_SETUP : IDLE_GAP)
                                              : ((CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP);
   localparam int WW   = (WMAX > 1) ? $clog2(WMAX) : 1;

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic          phase_q, phase_d;
   logic [3:0]    bit_q, bit_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [15:0]   frame_q, frame_d;
   logic [7:0]    rx_q, rx_d;
   logic          who_q, who_d;
   logic          last_q, last_d;

   logic          gnt_any, gnt_sel, rw_sel, resp_pulse, rd_phase;
   logic [6:0]    addr_sel;
   logic [7:0]    wd_sel;

   // On contention the requester that did not win last time gets the bus.
   assign gnt_any  = bus.req0_valid | bus.req1_valid;
   assign gnt_sel  = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
   assign rw_sel   = gnt_sel ? bus.req1_rw    : bus.req0_rw;
   assign addr_sel = gnt_sel ? bus.req1_addr  : bus.req0_addr;
   assign wd_sel   = gnt_sel ? bus.req1_wdata : bus.req0_wdata;
   assign rd_phase = frame_q[15] & (bit_q <= 4'd7);

   always_comb begin
      state_d        = state_q;
      div_d          = div_q;
      phase_d        = phase_q;
      bit_d          = bit_q;
      wait_d         = wait_q;
      frame_d        = frame_q;
      rx_d           = rx_q;
      who_d          = who_q;
      last_d         = last_q;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (gnt_any && reset) begin
               bus.req0_ready = ~gnt_sel;
               bus.req1_ready = gnt_sel;
               who_d          = gnt_sel;
               last_d         = gnt_sel;
               frame_d        = {rw_sel, addr_sel, rw_sel ? 8'h00 : wd_sel};
               rx_d           = '0;
               bit_d          = 4'd15;
               wait_d         = '0;
               state_d        = S_SETUP;
            end
         end
         S_SETUP: begin
            if (wait_q == WW'(CS_SETUP - 1)) begin
               div_d   = DW'(CLK_DIV - 1);
               phase_d = 1'b0;
               state_d = S_SHIFT;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         S_SHIFT: begin
            if (div_q == '0) begin
               div_d = DW'(CLK_DIV - 1);
               if (!phase_q) begin
                  // This edge raises SCLK: the slave's read bit is taken here.
                  phase_d = 1'b1;
                  if (rd_phase) rx_d = {rx_q[6:0], bus.ad_spi_sdio_i};
               end else begin
                  phase_d = 1'b0;
                  if (bit_q == 4'd0) begin
                     wait_d  = '0;
                     state_d = S_HOLD;
                  end else begin
                     bit_d = bit_q - 4'd1;
                  end
               end
            end else begin
               div_d = div_q - DW'(1);
            end
         end
         S_HOLD: begin
            if (wait_q == WW'(CS_HOLD - 1)) begin
               wait_d  = '0;
               state_d = S_GAP;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         S_GAP: begin
            if (wait_q == WW'(IDLE_GAP - 1)) state_d = S_IDLE;
            else                              wait_d  = wait_q + WW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         phase_q <= 1'b0;
         bit_q   <= 4'd15;
         wait_q  <= '0;
         frame_q <= '0;
         rx_q    <= '0;
         who_q   <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         wait_q  <= wait_d;
         frame_q <= frame_d;
         rx_q    <= rx_d;
         who_q   <= who_d;
         last_q  <= last_d;
      end
   end

   assign resp_pulse         = (state_q == S_GAP) && (wait_q == '0);
   assign bus.resp0_valid    = resp_pulse & ~who_q;
   assign bus.resp1_valid    = resp_pulse & who_q;
   assign bus.resp0_rdata    = (bus.resp0_valid && frame_q[15]) ? rx_q : 8'h00;
   assign bus.resp1_rdata    = (bus.resp1_valid && frame_q[15]) ? rx_q : 8'h00;
   assign bus.busy           = (state_q != S_IDLE);
   assign bus.ad_spi_cs      = !((state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD));
   assign bus.ad_spi_sclk    = (state_q == S_SHIFT) & phase_q;
   assign bus.ad_spi_sdio_oe = (state_q == S_SETUP) || ((state_q == S_SHIFT) && !rd_phase);
   assign bus.ad_spi_sdio_o  = ((state_q == S_SETUP) || (state_q == S_SHIFT)) ? frame_q[bit_q] : 1'b0;
endmodule

// File: tb/tb_lgdst_adspi_arb.sv
// Bench for lgdst_adspi_arb: default-parameter instance u[0] and minimum-timing instance u[1],
// each checked every cycle against a frame-offset model of the bus.
`timescale 1ns/1ps
module tb_lgdst_adspi_arb;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] rst_n;
   logic [1:0] v0, v1, rw0, rw1;
   logic [6:0] a0 [2];
   logic [6:0] a1 [2];
   logic [7:0] w0 [2];
   logic [7:0] w1 [2];
   logic [7:0] sbyte [2];

   logic [1:0] o_cs, o_sclk, o_sdo, o_oe, o_busy, o_rdy0, o_rdy1, o_rv0, o_rv1;
   logic [7:0] o_rd0 [2];
   logic [7:0] o_rd1 [2];

   int total = 0;
   int bad   = 0;
   int tphase = 0;

   function automatic int pd(int i); return (i == 0) ? 4 : 1; endfunction
   function automatic int ps(int i); return (i == 0) ? 2 : 1; endfunction
   function automatic int ph(int i); return (i == 0) ? 2 : 1; endfunction
   function automatic int pg(int i); return (i == 0) ? 4 : 1; endfunction

   for (genvar g = 0; g < 2; g++) begin : u
      lgdst_adspi_arb_if bus ();
      int rc = 0;

      lgdst_adspi_arb #(
         .CLK_DIV  ((g == 0) ? 4 : 1),
         .CS_SETUP ((g == 0) ? 2 : 1),
         .CS_HOLD  ((g == 0) ? 2 : 1),
         .IDLE_GAP ((g == 0) ? 4 : 1)
      ) dut (
         .clk   (clk),
         .reset (rst_n[g]),
         .bus   (bus)
      );

      // Slave: after the 8 command bits, present the read byte MSB first, one bit per SCLK rise.
      always @(posedge bus.ad_spi_sclk or posedge bus.ad_spi_cs) begin
         if (bus.ad_spi_cs) rc <= 0;
         else               rc <= rc + 1;
      end
      assign bus.ad_spi_sdio_i = (rc >= 8 && rc < 16) ? sbyte[g][3'(15 - rc)] : 1'b0;

      assign bus.req0_valid = v0[g];
      assign bus.req0_rw    = rw0[g];
      assign bus.req0_addr  = a0[g];
      assign bus.req0_wdata = w0[g];
      assign bus.req1_valid = v1[g];
      assign bus.req1_rw    = rw1[g];
      assign bus.req1_addr  = a1[g];
      assign bus.req1_wdata = w1[g];

      assign o_cs[g]   = bus.ad_spi_cs;
      assign o_sclk[g] = bus.ad_spi_sclk;
      assign o_sdo[g]  = bus.ad_spi_sdio_o;
      assign o_oe[g]   = bus.ad_spi_sdio_oe;
      assign o_busy[g] = bus.busy;
      assign o_rdy0[g] = bus.req0_ready;
      assign o_rdy1[g] = bus.req1_ready;
      assign o_rv0[g]  = bus.resp0_valid;
      assign o_rv1[g]  = bus.resp1_valid;
      assign o_rd0[g]  = bus.resp0_rdata;
      assign o_rd1[g]  = bus.resp1_rdata;
   end

   // Model state: offset k since accept, owner, frame bits, expected read byte.
   logic        m_act [2];
   int          m_k [2];
   logic        m_who [2];
   logic        m_last [2];
   logic [15:0] m_frame [2];
   logic [7:0]  m_rd [2];
   int          cyc = 0;
   int          acc_cyc [2];
   int          prev_acc [2];
   logic [15:0] cap [2];
   logic [1:0]  prev_sclk = '0;
   logic [5:0]  gseq = '0;
   int          ngr = 0;

   function automatic void chk(string nm, int i, logic [15:0] act, logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", nm, i, cyc, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      logic e_cs, e_sclk, e_oe, e_sdo, chk_sdo, e_busy, e_r0, e_r1, e_v0, e_v1, who, rw;
      logic [7:0] e_rd;
      int k, s, p, b, S, D, H, G;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         S = ps(i); D = pd(i); H = ph(i); G = pg(i);
         e_cs = 1'b1; e_sclk = 1'b0; e_oe = 1'b0; e_sdo = 1'b0; chk_sdo = 1'b0; e_busy = 1'b0;
         e_r0 = 1'b0; e_r1 = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0; e_rd = 8'h00;
         if (rst_n[i] !== 1'b1) begin
            chk_sdo   = 1'b1;
            m_act[i]  = 1'b0;
            m_last[i] = 1'b1;
            chk("rst_rd0", i, 16'(o_rd0[i]), 16'h0);
            chk("rst_rd1", i, 16'(o_rd1[i]), 16'h0);
         end else if (!m_act[i]) begin
            if (v0[i] || v1[i]) begin
               who = (v0[i] && v1[i]) ? ~m_last[i] : v1[i];
               e_r0 = ~who; e_r1 = who;
               rw = who ? rw1[i] : rw0[i];
               m_act[i]   = 1'b1;
               m_k[i]     = 1;
               m_who[i]   = who;
               m_last[i]  = who;
               m_frame[i] = {rw, who ? a1[i] : a0[i], rw ? 8'h00 : (who ? w1[i] : w0[i])};
               m_rd[i]    = rw ? sbyte[i] : 8'h00;
               prev_acc[i] = acc_cyc[i];
               acc_cyc[i]  = cyc;
               cap[i]      = '0;
               if (i == 0 && tphase == 3) begin
                  gseq = {gseq[4:0], who};
                  ngr++;
                  if (ngr == 6) chk("rr_order", i, 16'(gseq), 16'b010101);
               end
               if (i == 1 && tphase == 6 && who) chk("b2b_accept", i, 16'(cyc - prev_acc[i]), 16'd36);
            end
         end else begin
            k = m_k[i];
            e_busy = 1'b1;
            if (k <= S) begin
               e_cs = 1'b0; e_oe = 1'b1; e_sdo = m_frame[i][15]; chk_sdo = 1'b1;
            end else begin
               s = k - 1 - S;
               if (s < 32 * D) begin
                  p = s / (2 * D);
                  b = 15 - p;
                  e_cs = 1'b0;
                  e_sclk = ((s % (2 * D)) >= D);
                  e_oe = !(m_frame[i][15] && b <= 7);
                  e_sdo = m_frame[i][b];
                  chk_sdo = e_oe;
               end else if (s < 32 * D + H) begin
                  e_cs = 1'b0;
               end else if (s == 32 * D + H) begin
                  if (m_who[i]) e_v1 = 1'b1; else e_v0 = 1'b0 | 1'b1;
                  e_rd = m_rd[i];
               end
            end
            m_k[i] = k + 1;
            if (m_k[i] == 1 + S + 32 * D + H + G) m_act[i] = 1'b0;
         end

         chk("cs", i, 16'(o_cs[i]), 16'(e_cs));
         chk("sclk", i, 16'(o_sclk[i]), 16'(e_sclk));
         chk("sdio_oe", i, 16'(o_oe[i]), 16'(e_oe));
         if (chk_sdo) chk("sdio_o", i, 16'(o_sdo[i]), 16'(e_sdo));
         chk("busy", i, 16'(o_busy[i]), 16'(e_busy));
         chk("ready0", i, 16'(o_rdy0[i]), 16'(e_r0));
         chk("ready1", i, 16'(o_rdy1[i]), 16'(e_r1));
         chk("resp0_valid", i, 16'(o_rv0[i]), 16'(e_v0));
         chk("resp1_valid", i, 16'(o_rv1[i]), 16'(e_v1));
         if (e_v0) chk("resp0_rdata", i, 16'(o_rd0[i]), 16'(e_rd));
         if (e_v1) chk("resp1_rdata", i, 16'(o_rd1[i]), 16'(e_rd));

         if (o_sclk[i] && !prev_sclk[i]) cap[i] = {cap[i][14:0], o_sdo[i]};
         prev_sclk[i] = o_sclk[i];

         // Hand-computed anchors for the model itself.
         if (i == 0 && tphase == 1 && e_v0) begin
            chk("lat_write", i, 16'(cyc - acc_cyc[i]), 16'd133);
            chk("bits_write", i, cap[i], 16'h12A5);
            chk("rdata_write", i, 16'(o_rd0[i]), 16'h0000);
         end
         if (i == 0 && tphase == 2 && e_v1) begin
            chk("lat_read", i, 16'(cyc - acc_cyc[i]), 16'd133);
            chk("cmd_read", i, 16'(cap[i][15:8]), 16'h0085);
            chk("rdata_read", i, 16'(o_rd1[i]), 16'h003C);
         end
         if (i == 1 && tphase == 6 && e_v0) chk("lat_min", i, 16'(cyc - acc_cyc[i]), 16'd35);
      end
   end

   task automatic send(input int i, input int who, input logic rw, input logic [6:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      if (who == 0) begin rw0[i] = rw; a0[i] = a; w0[i] = d; v0[i] = 1'b1; end
      else          begin rw1[i] = rw; a1[i] = a; w1[i] = d; v1[i] = 1'b1; end
      for (int n = 0; ; n++) begin
         @(negedge clk);
         if ((who == 0) ? o_rdy0[i] : o_rdy1[i]) break;
         if (n > 3000) begin
            $display("FAIL ready_timeout inst=%0d req=%0d", i, who);
            $fatal(1, "no accept within cycle budget");
         end
      end
      @(posedge clk); #1;
      if (who == 0) v0[i] = 1'b0; else v1[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      for (int n = 0; ; n++) begin
         @(negedge clk);
         if (!o_busy[i]) break;
         if (n > 3000) begin
            $display("FAIL idle_timeout inst=%0d", i);
            $fatal(1, "busy never cleared");
         end
      end
   endtask

   initial begin
      rst_n = 2'b00;
      v0 = '0; v1 = '0; rw0 = '0; rw1 = '0;
      for (int i = 0; i < 2; i++) begin
         a0[i] = '0; a1[i] = '0; w0[i] = '0; w1[i] = '0; sbyte[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 2'b11;

      tphase = 1;
      send(0, 0, 1'b0, 7'h12, 8'hA5);
      wait_idle(0);

      tphase = 2;
      sbyte[0] = 8'h3C;
      send(0, 1, 1'b1, 7'h05, 8'h00);
      wait_idle(0);

      tphase = 3;
      sbyte[0] = 8'h5A;
      fork
         for (int n = 0; n < 3; n++) send(0, 0, 1'b0, 7'(8'h10 + n), 8'(8'h11 * (n + 1)));
         for (int n = 0; n < 3; n++) send(0, 1, 1'b1, 7'(8'h20 + n), 8'hFF);
      join
      wait_idle(0);

      tphase = 4;
      send(0, 0, 1'b0, 7'h44, 8'h3E);
      repeat (50) @(posedge clk);
      #1 rst_n[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n[0] = 1'b1;
      sbyte[0] = 8'h96;
      send(0, 0, 1'b1, 7'h33, 8'h00);
      wait_idle(0);

      tphase = 5;
      send(0, 1, 1'b0, 7'h2B, 8'hC7);
      @(posedge clk); #1;
      rw0[0] = 1'b0; a0[0] = 7'h01; w0[0] = 8'h77; v0[0] = 1'b1;
      repeat (20) @(posedge clk);
      #1 v0[0] = 1'b0;
      wait_idle(0);
      repeat (8) @(posedge clk);

      tphase = 6;
      sbyte[1] = 8'hC3;
      fork
         send(1, 0, 1'b0, 7'h7F, 8'h01);
         send(1, 1, 1'b1, 7'h00, 8'h00);
      join
      wait_idle(1);
      repeat (5) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
